disp_arbiter: RTL and testbench

- Shares the single 16-bit four-digit seven-segment display between NREQ requesters (score logic, debug counters, switch echo, etc.).
- Round-robin arbitration with a minimum dwell time in 1 ms ticks, so each requester's value stays readable before the display is handed to the next.
- The `disp_value` output drives the 16-bit `in` port of the display driver directly.
- Runs on the board clock with the same 10000-cycle prescale as the display driver (1 ms tick at 10 MHz).

---
 rtl/disp_pkg.sv | 37 +++
 rtl/disp_arbiter_tick_gen.sv | 33 +++
 rtl/disp_arbiter.sv | 109 ++++++++++
 tb/tb_disp_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types, defaults and the round-robin search used by the display arbiter.
// The search is sized for up to eight requesters.
package disp_pkg;

    typedef enum logic {IDLE, SERVE} state_t;

    localparam int          DEFAULT_TICK_DIV   = 10000;
    localparam int          DEFAULT_DWELL_MS   = 1000;
    localparam logic [15:0] DEFAULT_IDLE_VALUE = 16'h0000;
    localparam int          MAX_NREQ           = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set req bit at or after ptr+1, wrapping modulo nreq. The last
    // position searched is ptr itself, so the current owner always ranks lowest.
    function automatic rr_pick_t rr_next(input logic [2:0] ptr,
                                         input logic [MAX_NREQ-1:0] req,
                                         input int nreq);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            if (k <= nreq && !r.found) begin
                idx = (int'(ptr) + k) % nreq;
                if (req[idx[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_arbiter_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count for one
// cycle. A synchronous clear restarts the count from zero.
module tick_gen #(
    parameter int DIV = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner selection for the shared seven-segment display, with a
// minimum dwell per owner while others are waiting.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int          NREQ       = 4,
    parameter int          TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int          DWELL_MS   = DEFAULT_DWELL_MS,
    parameter logic [15:0] IDLE_VALUE = DEFAULT_IDLE_VALUE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] data_flat,
    output logic [15:0]        disp_value,
    output logic [NREQ-1:0]    grant,
    output logic               busy
);

    localparam int DW = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;

    state_t         state_q;
    logic [2:0]     ptr_q;
    logic [DW-1:0]  dwell_q;
    logic [NREQ-1:0] grant_q;
    logic           busy_q;
    logic [15:0]    disp_q;

    logic [MAX_NREQ-1:0] req_ext;
    rr_pick_t       pick;
    logic           tick;
    logic           released;
    logic           others_pending;
    logic           expired;
    logic           switch_now;
    logic           new_grant;
    logic [15:0]    pick_data;
    logic [15:0]    cur_data;

    assign req_ext        = MAX_NREQ'(req);
    assign pick           = rr_next(ptr_q, req_ext, NREQ);
    assign released       = !req_ext[ptr_q];
    assign others_pending = |(req & ~grant_q);
    // The dwell counts as complete on the tick that will saturate it, so the
    // handover edge lands exactly DWELL_MS*TICK_DIV cycles after the grant.
    assign expired        = (dwell_q == DW'(DWELL_MS)) ||
                            (tick && (dwell_q == DW'(DWELL_MS - 1)));
    assign switch_now     = (state_q == SERVE) && (released || (expired && others_pending));
    assign new_grant      = pick.found && ((state_q == IDLE) || switch_now);
    assign pick_data      = data_flat[16*pick.idx +: 16];
    assign cur_data       = data_flat[16*ptr_q +: 16];

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (new_grant),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'(NREQ - 1);
            dwell_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            disp_q  <= IDLE_VALUE;
        end else if (new_grant) begin
            state_q <= SERVE;
            ptr_q   <= pick.idx;
            dwell_q <= '0;
            grant_q <= NREQ'(1) << pick.idx;
            busy_q  <= 1'b1;
            disp_q  <= pick_data;
        end else begin
            case (state_q)
                IDLE: begin
                    disp_q <= IDLE_VALUE;
                end
                SERVE: begin
                    if (switch_now) begin
                        // Owner released and nobody else is asking.
                        state_q <= IDLE;
                        dwell_q <= '0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        disp_q  <= IDLE_VALUE;
                    end else begin
                        disp_q <= cur_data;
                        if (tick && (dwell_q != DW'(DWELL_MS))) begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    disp_q  <= IDLE_VALUE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign disp_value = disp_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with a short dwell (TICK_DIV=4, DWELL_MS=3,
// 12-cycle dwell); expected values are hand-computed constants.
module tb_disp_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [16*NREQ-1:0] data_flat = '0;
    logic [15:0]        disp_value;
    logic [NREQ-1:0]    grant;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;

    disp_arbiter #(
        .NREQ       (NREQ),
        .TICK_DIV   (4),
        .DWELL_MS   (3),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_flat  (data_flat),
        .disp_value (disp_value),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        req       = '0;
        data_flat = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        rst_n     = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want %b", busy, 1'b0); end
        n_cmp++; if (disp_value !== 16'h0000) begin n_err++; $display("FAIL reset_disp: got %h want %h", disp_value, 16'h0000); end
        cyc(3);
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL idle_grant: got %b want %b", grant, 4'b0000); end
    endtask

    task automatic test_single_grant();
        do_reset();
        data_flat[32 +: 16] = 16'h1234;
        req = 4'b0100;
        cyc(1);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t1_grant: got %b want %b", grant, 4'b0100); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want %b", busy, 1'b1); end
        n_cmp++; if (disp_value !== 16'h1234) begin n_err++; $display("FAIL t1_disp: got %h want %h", disp_value, 16'h1234); end
        data_flat[32 +: 16] = 16'hBEEF;
        #1;
        n_cmp++; if (disp_value !== 16'h1234) begin n_err++; $display("FAIL t1_disp_latency: got %h want %h", disp_value, 16'h1234); end
        cyc(1);
        n_cmp++; if (disp_value !== 16'hBEEF) begin n_err++; $display("FAIL t1_disp_follow: got %h want %h", disp_value, 16'hBEEF); end
    endtask

    task automatic test_dwell_rotation();
        do_reset();
        req = 4'b0101;
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t2_first: got %b want %b", grant, 4'b0001); end
        n_cmp++; if (disp_value !== 16'hA000) begin n_err++; $display("FAIL t2_first_disp: got %h want %h", disp_value, 16'hA000); end
        cyc(11);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t2_hold0: got %b want %b", grant, 4'b0001); end
        cyc(1);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t2_hand2: got %b want %b", grant, 4'b0100); end
        n_cmp++; if (disp_value !== 16'hC002) begin n_err++; $display("FAIL t2_hand2_disp: got %h want %h", disp_value, 16'hC002); end
        cyc(11);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t2_hold2: got %b want %b", grant, 4'b0100); end
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t2_back0: got %b want %b", grant, 4'b0001); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t2_busy: got %b want %b", busy, 1'b1); end
    endtask

    task automatic test_sole_hold();
        do_reset();
        req = 4'b0010;
        cyc(1);
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t3_grant: got %b want %b", grant, 4'b0010); end
        cyc(49);
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t3_hold50: got %b want %b", grant, 4'b0010); end
        req = 4'b1010;
        cyc(1);
        n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL t3_hand3: got %b want %b", grant, 4'b1000); end
        n_cmp++; if (disp_value !== 16'hD003) begin n_err++; $display("FAIL t3_disp: got %h want %h", disp_value, 16'hD003); end
    endtask

    task automatic test_release_handover();
        do_reset();
        req = 4'b0101;
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t4_grant0: got %b want %b", grant, 4'b0001); end
        cyc(4);
        req = 4'b0100;
        cyc(1);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t4_release: got %b want %b", grant, 4'b0100); end
        req = 4'b0101;
        cyc(11);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t4_full_dwell: got %b want %b", grant, 4'b0100); end
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t4_expire: got %b want %b", grant, 4'b0001); end
    endtask

    task automatic test_release_to_idle();
        do_reset();
        req = 4'b0001;
        cyc(4);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t5_grant: got %b want %b", grant, 4'b0001); end
        req = 4'b0000;
        cyc(1);
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t5_grant_idle: got %b want %b", grant, 4'b0000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy: got %b want %b", busy, 1'b0); end
        n_cmp++; if (disp_value !== 16'h0000) begin n_err++; $display("FAIL t5_disp: got %h want %h", disp_value, 16'h0000); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        cyc(5);
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t6_pre: got %b want %b", grant, 4'b0010); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t6_grant: got %b want %b", grant, 4'b0000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_busy: got %b want %b", busy, 1'b0); end
        n_cmp++; if (disp_value !== 16'h0000) begin n_err++; $display("FAIL t6_disp: got %h want %h", disp_value, 16'h0000); end
        req = 4'b1111;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t6_first: got %b want %b", grant, 4'b0001); end
    endtask

    task automatic test_back_to_back();
        // All four requesting: each owner holds a full dwell, in index order.
        do_reset();
        req = 4'b1111;
        cyc(1);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t7_r0: got %b want %b", grant, 4'b0001); end
        cyc(12);
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t7_r1: got %b want %b", grant, 4'b0010); end
        cyc(12);
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t7_r2: got %b want %b", grant, 4'b0100); end
        cyc(12);
        n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL t7_r3: got %b want %b", grant, 4'b1000); end
        cyc(12);
        n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t7_wrap: got %b want %b", grant, 4'b0001); end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_dwell_rotation();
        test_sole_hold();
        test_release_handover();
        test_release_to_idle();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
